// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - rebuilds hcount/vcount from an incoming VGA sync/blank stream and tracks timing lock
module vga_sync_decoder #(
    parameter int LOCK_FRAMES  = 2,
    parameter int TIMEOUT      = 2688,
    parameter int H_COUNT_TOT  = 1344,
    parameter int H_BLNK_START = 1024,
    parameter int H_SYNC_START = 1048,
    parameter int V_COUNT_TOT  = 806,
    parameter int V_BLNK_START = 768,
    parameter int V_SYNC_START = 771
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        locked,
    output logic        timing_err,
    output logic        frame_start
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQ      = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 2);

    localparam logic [10:0]       H_LAST   = 11'(H_COUNT_TOT - 1);
    localparam logic [10:0]       V_LAST   = 11'(V_COUNT_TOT - 1);
    localparam logic [10:0]       H_SYNC   = 11'(H_SYNC_START);
    localparam logic [10:0]       V_SYNC   = 11'(V_SYNC_START);
    localparam logic [10:0]       H_BLNK   = 11'(H_BLNK_START);
    localparam logic [10:0]       V_BLNK   = 11'(V_BLNK_START);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_FRAMES);

    // Stage 1 (r_*) and the previous stage-1 syncs (rd_*) used for edge detection
    logic r_hs, r_vs, r_hb, r_vb;
    logic rd_hs, rd_vs;

    logic [1:0]        state, state_next;
    logic [GOOD_W-1:0] good_cnt, good_next;
    logic [TO_W-1:0]   to_cnt, to_next;

    logic        hs_edge, vs_edge;
    logic [10:0] pred_h, pred_v, next_h, next_v;
    logic        timeout, sync_mis, blank_mis, err_next;

    assign hs_edge = r_hs && !rd_hs;
    assign vs_edge = r_vs && !rd_vs;
    assign locked  = (state == ST_LOCKED);

    // Free-running prediction from the pixel currently on the outputs, then resync on edges
    always_comb begin
        pred_h = (hcount_out == H_LAST) ? 11'd0 : hcount_out + 11'd1;
        pred_v = vcount_out;
        if (hcount_out == H_LAST) begin
            pred_v = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        end
        next_h = pred_h;
        next_v = pred_v;
        if (hs_edge) begin
            next_h = H_SYNC;
        end
        if (vs_edge) begin
            next_h = 11'd0;
            next_v = V_SYNC;
        end
    end

    always_comb begin
        to_next = '0;
        if (!hs_edge) begin
            to_next = (to_cnt == TO_MAX) ? TO_MAX : to_cnt + TO_W'(1);
        end
        timeout = (to_next == TO_MAX);
    end

    // A same-pixel hsync+vsync edge always trips the hcount checks since H_SYNC is nonzero
    always_comb begin
        sync_mis  = (hs_edge && (pred_h != H_SYNC))
                 || (vs_edge && ((pred_h != 11'd0) || (pred_v != V_SYNC)))
                 || timeout;
        blank_mis = (r_hb != (next_h >= H_BLNK)) || (r_vb != (next_v >= V_BLNK));
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = 1'b0;
        if (timeout) begin
            state_next = ST_UNLOCKED;
            err_next   = (state == ST_LOCKED);
        end else begin
            case (state)
                ST_UNLOCKED: begin
                    if (vs_edge) begin
                        state_next = ST_ACQ;
                        good_next  = '0;
                    end
                end
                ST_ACQ: begin
                    if (sync_mis) begin
                        state_next = ST_UNLOCKED;
                    end else if (vs_edge) begin
                        good_next = good_cnt + GOOD_W'(1);
                        if (good_next >= GOOD_TGT) begin
                            state_next = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sync_mis || blank_mis) begin
                        state_next = ST_UNLOCKED;
                        err_next   = 1'b1;
                    end
                end
                default: state_next = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            r_hb        <= 1'b0;
            r_vb        <= 1'b0;
            rd_hs       <= 1'b0;
            rd_vs       <= 1'b0;
            state       <= ST_UNLOCKED;
            good_cnt    <= '0;
            to_cnt      <= '0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            timing_err  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_hs        <= hsync_in;
            r_vs        <= vsync_in;
            r_hb        <= hblnk_in;
            r_vb        <= vblnk_in;
            rd_hs       <= r_hs;
            rd_vs       <= r_vs;
            state       <= state_next;
            good_cnt    <= good_next;
            to_cnt      <= to_next;
            hcount_out  <= next_h;
            vcount_out  <= next_v;
            hsync_out   <= r_hs;
            vsync_out   <= r_vs;
            hblnk_out   <= r_hb;
            vblnk_out   <= r_vb;
            timing_err  <= err_next;
            frame_start <= (next_h == 11'd0) && (next_v == 11'd0) && (state_next == ST_LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced-size frame
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    localparam int H_TOT = 40, H_BLNK = 32, H_SYNC = 34, H_SEND = 38;
    localparam int V_TOT = 12, V_BLNK = 9,  V_SYNC = 10, V_SEND = 11;
    localparam int LOCKF = 2,  TMO = 80;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic        locked, timing_err, frame_start;

    vga_sync_decoder #(
        .LOCK_FRAMES(LOCKF), .TIMEOUT(TMO),
        .H_COUNT_TOT(H_TOT), .H_BLNK_START(H_BLNK), .H_SYNC_START(H_SYNC),
        .V_COUNT_TOT(V_TOT), .V_BLNK_START(V_BLNK), .V_SYNC_START(V_SYNC)
    ) dut (
        .clk(clk), .rst(rst),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .locked(locked), .timing_err(timing_err), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic hs, vs, hb, vb, lk, er, fs;
    } obs_t;

    obs_t sb_q[$];
    obs_t mon_act, mon_exp;
    int   vecs = 0, fails = 0, err_seen = 0, fs_seen = 0;
    bit   mon_en = 1'b0;

    // Reference: position kept as one linear pixel index within the frame
    int m_pos = 0, m_k = 0, m_last_hs_k = 0, m_state = 0, m_good = 0;
    bit m_phs = 1'b0, m_pvs = 1'b0;

    task automatic ref_step(input bit hs, input bit vs, input bit hb, input bit vb);
        obs_t e;
        int   pred, ph, pv, nh, nv;
        bit   hse, vse, tmo, mis, bbad, err;
        pred = (m_pos + 1) % FRAME;
        ph   = pred % H_TOT;
        pv   = pred / H_TOT;
        hse  = hs && !m_phs;
        vse  = vs && !m_pvs;
        m_phs = hs;
        m_pvs = vs;
        m_pos = pred;
        if (hse) m_pos = pv * H_TOT + H_SYNC;
        if (vse) m_pos = V_SYNC * H_TOT;
        nh = m_pos % H_TOT;
        nv = m_pos / H_TOT;
        m_k++;
        if (hse) m_last_hs_k = m_k;
        tmo  = (m_k - m_last_hs_k) >= TMO;
        mis  = (hse && ph != H_SYNC) || (vse && (ph != 0 || pv != V_SYNC)) || tmo;
        bbad = (hb != (nh >= H_BLNK)) || (vb != (nv >= V_BLNK));
        err  = 1'b0;
        if (tmo) begin
            err = (m_state == 2);
            m_state = 0;
        end else if (m_state == 0) begin
            if (vse) begin m_state = 1; m_good = 0; end
        end else if (m_state == 1) begin
            if (mis) m_state = 0;
            else if (vse) begin
                m_good++;
                if (m_good >= LOCKF) m_state = 2;
            end
        end else if (mis || bbad) begin
            err = 1'b1;
            m_state = 0;
        end
        e.h  = 11'(nh);
        e.v  = 11'(nv);
        e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
        e.lk = (m_state == 2);
        e.er = err;
        e.fs = (m_pos == 0) && (m_state == 2);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                       locked, timing_err, frame_start};
            if (timing_err) err_seen++;
            if (frame_start) fs_seen++;
            vecs++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: output seen with no expected entry at %0t", $time);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    fails++;
                    $display("FAIL pixel@%0t: got h=%0d v=%0d syncblk=%b%b%b%b lk=%b err=%b fs=%b, required h=%0d v=%0d syncblk=%b%b%b%b lk=%b err=%b fs=%b",
                             $time, mon_act.h, mon_act.v, mon_act.hs, mon_act.vs, mon_act.hb, mon_act.vb,
                             mon_act.lk, mon_act.er, mon_act.fs, mon_exp.h, mon_exp.v, mon_exp.hs,
                             mon_exp.vs, mon_exp.hb, mon_exp.vb, mon_exp.lk, mon_exp.er, mon_exp.fs);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic put(input bit hs, input bit vs, input bit hb, input bit vb);
        @(posedge clk);
        #1;
        hsync_in = hs;
        vsync_in = vs;
        hblnk_in = hb;
        vblnk_in = vb;
        ref_step(hs, vs, hb, vb);
    endtask

    // code: 0 clean, 1 hsync +1 on line 3, 2 hblnk glitch, 3 hsync on vsync pixel, 4 hsync gap, 5 noise
    task automatic run_frame(input int code, input int npix);
        int n;
        n = 0;
        for (int gv = 0; gv < V_TOT; gv++) begin
            for (int gh = 0; gh < H_TOT; gh++) begin
                bit hs, vs, hb, vb;
                if (n == npix) return;
                hs = (gh >= H_SYNC) && (gh < H_SEND);
                vs = (gv >= V_SYNC) && (gv < V_SEND);
                hb = (gh >= H_BLNK);
                vb = (gv >= V_BLNK);
                case (code)
                    1: if (gv == 3) hs = (gh >= H_SYNC + 1) && (gh < H_SEND);
                    2: if (gv == 2 && gh == 5) hb = 1'b1;
                    3: if (gv == V_SYNC && gh == 0) hs = 1'b1;
                    4: if (gv >= 1 && gv <= 3) hs = 1'b0;
                    5: begin
                        if ($urandom_range(0, 99) == 0) begin
                            case ($urandom_range(0, 3))
                                0: hs = !hs;
                                1: vs = !vs;
                                2: hb = !hb;
                                default: vb = !vb;
                            endcase
                        end
                    end
                    default: ;
                endcase
                put(hs, vs, hb, vb);
                n++;
            end
        end
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
              vblnk_out, locked, timing_err, frame_start}), 0);
        #1;
        rst = 1'b0;
        ref_step(0, 0, 0, 0);
        ref_step(0, 0, 0, 0);
        mon_en = 1'b1;

        for (int f = 0; f < 4; f++) run_frame(0, FRAME);
        check("lock_after_3_vsync", locked, 1);
        check("frame_start_once", fs_seen, 1);
        check("clean_no_err", err_seen, 0);

        e0 = err_seen;
        run_frame(1, FRAME);
        check("hshift_err_pulse", err_seen - e0, 1);
        check("hshift_unlocked", locked, 0);
        run_frame(0, FRAME);
        check("hshift_still_acq", locked, 0);
        run_frame(0, FRAME);
        check("hshift_relock", locked, 1);

        e0 = err_seen;
        run_frame(2, FRAME);
        check("hblnk_locked_err", err_seen - e0, 1);
        e0 = err_seen;
        run_frame(2, FRAME);
        run_frame(3, FRAME);
        check("acq_glitches_no_err", err_seen - e0, 0);
        check("dual_edge_unlocked", locked, 0);

        for (int f = 0; f < 3; f++) run_frame(0, FRAME);
        check("relock_after_dual", locked, 1);
        e0 = err_seen;
        run_frame(4, FRAME);
        check("timeout_err_pulse", err_seen - e0, 1);
        check("timeout_unlocked", locked, 0);
        for (int f = 0; f < 2; f++) run_frame(0, FRAME);
        check("relock_after_timeout", locked, 1);

        for (int f = 0; f < 3; f++) run_frame(5, FRAME);
        for (int f = 0; f < 4; f++) run_frame(0, FRAME);
        run_frame(0, 5 * H_TOT + 20);
        check("locked_before_reset", locked, 1);

        mon_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
              vblnk_out, locked, timing_err, frame_start}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
